spi_flash_read_seq: RTL and testbench

Command sequencer that drives the byte-level spi_controller to perform complete SPI-flash read transactions. The CPU or boot logic supplies start, addr and len. The block then:
- asserts CS;
- shifts out opcode, address bytes and dummy bytes;
- clocks in len data bytes and presents them on a valid/ready byte stream;
- deasserts CS and pulses done.

It sits between the iomem/boot logic and spi_controller, replacing per-byte software strobing for bulk reads.

---
 rtl/spi_seq_pkg.sv | 34 +++
 rtl/spi_flash_read_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_flash_read_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI-flash read sequencer.
package spi_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StLaunch,
      StAck,
      StWait,
      StPresent,
      StHold,
      StFin
   } state_e;

   typedef enum logic [1:0] {
      PhCmd,
      PhAddr,
      PhDummy,
      PhData
   } phase_e;

   localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
   localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;
   localparam logic [7:0] SPI_FILL            = 8'hFF;

   // Address byte number idx of an nbytes-wide address, most significant byte first.
   function automatic logic [7:0] addr_byte(input logic [31:0] a, input int unsigned nbytes,
                                            input logic [3:0] idx);
      logic [31:0] sh;
      sh = a >> (8 * (nbytes - 1 - 32'(idx)));
      return sh[7:0];
   endfunction

endpackage

// File: rtl/spi_flash_read_seq.sv
// SPI-flash read sequencer: drives a byte-level SPI controller through opcode, address,
// dummy and data bytes and streams the received data out on a valid/ready port.
module spi_flash_read_seq
   import spi_seq_pkg::*;
#(
   parameter logic [7:0]  OPCODE      = FLASH_CMD_READ,
   parameter int unsigned ADDR_BYTES  = 3,
   parameter int unsigned DUMMY_BYTES = 0,
   parameter logic [2:0]  SPI_MODE    = 3'd1,
   parameter int unsigned CS_SETUP    = 2,
   parameter int unsigned CS_HOLD     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [15:0] len,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        spi_cs,
   output logic [2:0]  spi_mode,
   output logic [7:0]  spi_byte_tx,
   output logic        spi_byte_tx_strobe,
   input  logic [7:0]  spi_byte_rx,
   input  logic        spi_idle
);

   state_e      state_q, state_d;
   phase_e      phase_q, phase_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] remaining_q, remaining_d;
   logic [31:0] addr_q, addr_d;
   logic        abort_q, abort_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_data_q, out_data_d;
   logic [7:0]  tx_q, tx_d;

   logic        abort_now;
   logic        addr_last;
   logic        go_after_addr;
   logic        go_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         phase_q     <= PhCmd;
         idx_q       <= '0;
         cnt_q       <= '0;
         remaining_q <= '0;
         addr_q      <= '0;
         abort_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         tx_q        <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         abort_q     <= abort_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         tx_q        <= tx_d;
      end
   end

   // An abort seen this cycle acts at once as well as being remembered.
   assign abort_now = abort_q || (abort && (state_q != StIdle));
   assign addr_last = (idx_q == 4'(ADDR_BYTES - 1));

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      remaining_d   = remaining_q;
      addr_d        = addr_q;
      abort_d       = abort_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      tx_d          = tx_q;
      go_after_addr = 1'b0;
      go_data       = 1'b0;

      if (state_q != StIdle && abort) begin
         abort_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            abort_d = 1'b0;
            if (start) begin
               addr_d      = addr;
               remaining_d = len;
               phase_d     = PhCmd;
               idx_d       = '0;
               cnt_d       = '0;
               state_d     = StSetup;
            end
         end

         StSetup: begin
            if (abort_now) begin
               cnt_d   = '0;
               state_d = StHold;
            end else if (cnt_q == 16'(CS_SETUP - 1)) begin
               cnt_d   = '0;
               state_d = StLaunch;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         StLaunch: state_d = StAck;

         // spi_idle can still be high here from before the strobe, so it is not looked at.
         StAck: state_d = StWait;

         StWait: begin
            if (spi_idle) begin
               if (abort_now) begin
                  cnt_d   = '0;
                  state_d = StHold;
               end else begin
                  unique case (phase_q)
                     PhCmd: begin
                        phase_d = PhAddr;
                        idx_d   = '0;
                        state_d = StLaunch;
                     end
                     PhAddr: begin
                        if (addr_last) begin
                           go_after_addr = 1'b1;
                        end else begin
                           idx_d   = idx_q + 4'd1;
                           state_d = StLaunch;
                        end
                     end
                     PhDummy: begin
                        if (idx_q == 4'(DUMMY_BYTES - 1)) begin
                           go_data = 1'b1;
                        end else begin
                           idx_d   = idx_q + 4'd1;
                           state_d = StLaunch;
                        end
                     end
                     PhData: begin
                        out_data_d  = spi_byte_rx;
                        out_valid_d = 1'b1;
                        state_d     = StPresent;
                     end
                  endcase
               end
            end
         end

         // No new strobe leaves while a byte is held here, so backpressure stalls the SPI clock.
         StPresent: begin
            if (abort_now) begin
               out_valid_d = 1'b0;
               cnt_d       = '0;
               state_d     = StHold;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  cnt_d   = '0;
                  state_d = StHold;
               end else begin
                  state_d = StLaunch;
               end
            end
         end

         StHold: begin
            if (cnt_q == 16'(CS_HOLD - 1)) begin
               cnt_d   = '0;
               state_d = StFin;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         StFin: begin
            abort_d = 1'b0;
            state_d = StIdle;
         end
      endcase

      if (go_after_addr) begin
         idx_d = '0;
         if (DUMMY_BYTES != 0) begin
            phase_d = PhDummy;
            state_d = StLaunch;
         end else begin
            go_data = 1'b1;
         end
      end

      if (go_data) begin
         if (remaining_q != 16'd0) begin
            phase_d = PhData;
            state_d = StLaunch;
         end else begin
            cnt_d   = '0;
            state_d = StHold;
         end
      end

      if (state_d == StLaunch) begin
         case (phase_d)
            PhCmd:   tx_d = OPCODE;
            PhAddr:  tx_d = addr_byte(addr_q, ADDR_BYTES, idx_d);
            default: tx_d = SPI_FILL;
         endcase
      end
   end

   // Moore decode keeps CS and strobe tied to the state register, so reset clears them at once.
   assign spi_cs             = (state_q == StIdle) || (state_q == StFin);
   assign busy               = (state_q != StIdle);
   assign done               = (state_q == StFin);
   assign spi_byte_tx_strobe = (state_q == StLaunch);
   assign spi_byte_tx        = tx_q;
   assign spi_mode           = SPI_MODE;
   assign out_valid          = out_valid_q;
   assign out_data           = out_data_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq with a small SPI controller model per instance.
module tb_spi_flash_read_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start, abort, out_ready, spi_idle;
   logic [31:0] addr;
   logic [15:0] len;
   logic [7:0]  spi_byte_rx;
   logic        busy, done, out_valid, spi_cs, spi_byte_tx_strobe;
   logic [7:0]  out_data, spi_byte_tx;
   logic [2:0]  spi_mode;

   logic        f_start, f_abort, f_out_ready, f_spi_idle;
   logic [31:0] f_addr;
   logic [15:0] f_len;
   logic [7:0]  f_spi_byte_rx;
   logic        f_busy, f_done, f_out_valid, f_spi_cs, f_spi_byte_tx_strobe;
   logic [7:0]  f_out_data, f_spi_byte_tx;
   logic [2:0]  f_spi_mode;

   int vectors = 0;
   int miscompares = 0;

   spi_flash_read_seq dut (
      .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len), .abort(abort),
      .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .spi_cs(spi_cs), .spi_mode(spi_mode), .spi_byte_tx(spi_byte_tx),
      .spi_byte_tx_strobe(spi_byte_tx_strobe), .spi_byte_rx(spi_byte_rx), .spi_idle(spi_idle)
   );

   spi_flash_read_seq #(.OPCODE(8'h0B), .DUMMY_BYTES(1)) dut_f (
      .clk(clk), .reset(reset), .start(f_start), .addr(f_addr), .len(f_len), .abort(f_abort),
      .busy(f_busy), .done(f_done), .out_data(f_out_data), .out_valid(f_out_valid),
      .out_ready(f_out_ready), .spi_cs(f_spi_cs), .spi_mode(f_spi_mode),
      .spi_byte_tx(f_spi_byte_tx), .spi_byte_tx_strobe(f_spi_byte_tx_strobe),
      .spi_byte_rx(f_spi_byte_rx), .spi_idle(f_spi_idle)
   );

   // Controller model: idle drops one cycle after the strobe, stays low 3 cycles, then
   // returns rx = 0x9C + (byte number within this CS-low period).
   logic       m_pend, f_pend;
   logic [2:0] m_cnt, f_cnt;
   logic [7:0] m_n, m_rx, f_n;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pend <= 1'b0; m_cnt <= '0; m_n <= '0; m_rx <= '0;
         spi_idle <= 1'b1; spi_byte_rx <= '0;
      end else begin
         if (spi_cs) m_n <= '0;
         else if (spi_byte_tx_strobe) begin
            m_n <= m_n + 8'd1; m_rx <= 8'h9C + m_n; m_pend <= 1'b1;
         end
         if (m_pend) begin
            m_pend <= 1'b0; spi_idle <= 1'b0; m_cnt <= 3'd3;
         end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 3'd1;
            if (m_cnt == 3'd1) begin spi_idle <= 1'b1; spi_byte_rx <= m_rx; end
         end
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         f_pend <= 1'b0; f_cnt <= '0; f_n <= '0; f_spi_idle <= 1'b1; f_spi_byte_rx <= '0;
      end else begin
         if (f_spi_cs) f_n <= '0;
         else if (f_spi_byte_tx_strobe) begin f_n <= f_n + 8'd1; f_pend <= 1'b1; end
         if (f_pend) begin
            f_pend <= 1'b0; f_spi_idle <= 1'b0; f_cnt <= 3'd3;
         end else if (f_cnt != 0) begin
            f_cnt <= f_cnt - 3'd1;
            if (f_cnt == 3'd1) begin f_spi_idle <= 1'b1; f_spi_byte_rx <= 8'h9C + f_n; end
         end
      end
   end

   // Monitor, sampled on the falling edge.
   logic [7:0] tx_log[$], out_log[$], ftx_log[$];
   int   done_cnt = 0, fdone_cnt = 0, fvalid_cnt = 0;
   int   strobe_in_valid = 0, unstable = 0, cs_gap = 0;
   int   setup_cnt = 0, setup_rec = -1, hold_cnt = 0, hold_rec = -1;
   logic seen_strobe = 1'b0, cs_was_low = 1'b0, prev_stall = 1'b0;
   logic [7:0] prev_data = '0;

   always @(negedge clk) begin
      if (spi_byte_tx_strobe) tx_log.push_back(spi_byte_tx);
      if (out_valid && out_ready) out_log.push_back(out_data);
      if (done) done_cnt++;
      if (spi_byte_tx_strobe && out_valid) strobe_in_valid++;
      if (prev_stall && out_valid && out_data !== prev_data) unstable++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (busy && !done && spi_cs) cs_gap++;
      if (!spi_cs) begin
         if (!seen_strobe) begin
            if (spi_byte_tx_strobe) begin seen_strobe = 1'b1; setup_rec = setup_cnt; end
            else setup_cnt++;
         end
         if (spi_byte_tx_strobe || out_valid || !spi_idle) hold_cnt = 0;
         else hold_cnt++;
         cs_was_low = 1'b1;
      end else begin
         if (cs_was_low) hold_rec = hold_cnt;
         cs_was_low = 1'b0; seen_strobe = 1'b0; setup_cnt = 0; hold_cnt = 0;
      end
      if (f_spi_byte_tx_strobe) ftx_log.push_back(f_spi_byte_tx);
      if (f_done) fdone_cnt++;
      if (f_out_valid) fvalid_cnt++;
   end

   task automatic clear_logs();
      tx_log.delete(); out_log.delete(); ftx_log.delete();
      done_cnt = 0; fdone_cnt = 0; fvalid_cnt = 0;
      strobe_in_valid = 0; unstable = 0; cs_gap = 0;
   endtask

   task automatic go(input logic [31:0] a, input logic [15:0] l);
      start = 1'b1; addr = a; len = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 0; abort = 0; out_ready = 0; addr = '0; len = '0;
      f_start = 0; f_abort = 0; f_out_ready = 1; f_addr = '0; f_len = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL rst_cs got %b want 1", spi_cs); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", out_valid); end
      vectors++; if (spi_byte_tx_strobe !== 1'b0) begin miscompares++; $display("FAIL rst_strobe got %b want 0", spi_byte_tx_strobe); end
      vectors++; if (spi_byte_tx !== 8'h00) begin miscompares++; $display("FAIL rst_tx got %h want 00", spi_byte_tx); end
      vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data got %h want 00", out_data); end
      vectors++; if (spi_mode !== 3'd1) begin miscompares++; $display("FAIL rst_mode got %0d want 1", spi_mode); end
      vectors++; if (f_spi_mode !== 3'd1) begin miscompares++; $display("FAIL rst_fmode got %0d want 1", f_spi_mode); end
   endtask

   task automatic test_basic_read();
      logic [7:0] etx[8];
      logic [7:0] eout[4];
      etx  = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      eout = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      clear_logs();
      out_ready = 1'b1;
      go(32'h7712_3456, 16'd4);
      vectors++; if (spi_cs !== 1'b0) begin miscompares++; $display("FAIL basic_cs_after_accept got %b want 0", spi_cs); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_after_accept got %b want 1", busy); end
      wait_idle();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_timeout busy got %b want 0", busy); end
      vectors++; if (tx_log.size() !== 8) begin miscompares++; $display("FAIL basic_tx_count got %0d want 8", tx_log.size()); end
      for (int i = 0; i < 8 && i < tx_log.size(); i++) begin
         vectors++; if (tx_log[i] !== etx[i]) begin miscompares++; $display("FAIL basic_tx[%0d] got %h want %h", i, tx_log[i], etx[i]); end
      end
      vectors++; if (out_log.size() !== 4) begin miscompares++; $display("FAIL basic_out_count got %0d want 4", out_log.size()); end
      for (int i = 0; i < 4 && i < out_log.size(); i++) begin
         vectors++; if (out_log[i] !== eout[i]) begin miscompares++; $display("FAIL basic_out[%0d] got %h want %h", i, out_log[i], eout[i]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done got %0d want 1", done_cnt); end
      vectors++; if (cs_gap !== 0) begin miscompares++; $display("FAIL basic_cs_gap got %0d want 0", cs_gap); end
      vectors++; if (setup_rec !== 2) begin miscompares++; $display("FAIL basic_cs_setup got %0d want 2", setup_rec); end
      vectors++; if (hold_rec !== 2) begin miscompares++; $display("FAIL basic_cs_hold got %0d want 2", hold_rec); end
      vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL basic_cs_end got %b want 1", spi_cs); end
   endtask

   task automatic test_backpressure();
      logic [7:0] eout[3];
      eout = '{8'hA0, 8'hA1, 8'hA2};
      clear_logs();
      out_ready = 1'b0;
      go(32'h0012_3456, 16'd3);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 400 && out_valid !== 1'b1; i++) @(negedge clk);
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_timeout[%0d] got %b want 1", k, out_valid); end
         repeat (20) @(negedge clk);
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held[%0d] got %b want 1", k, out_valid); end
         @(posedge clk); #1 out_ready = 1'b1;
         @(posedge clk); #1 out_ready = 1'b0;
      end
      wait_idle();
      vectors++; if (out_log.size() !== 3) begin miscompares++; $display("FAIL bp_out_count got %0d want 3", out_log.size()); end
      for (int i = 0; i < 3 && i < out_log.size(); i++) begin
         vectors++; if (out_log[i] !== eout[i]) begin miscompares++; $display("FAIL bp_out[%0d] got %h want %h", i, out_log[i], eout[i]); end
      end
      vectors++; if (strobe_in_valid !== 0) begin miscompares++; $display("FAIL bp_strobe_while_valid got %0d want 0", strobe_in_valid); end
      vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL bp_data_unstable got %0d want 0", unstable); end
      vectors++; if (tx_log.size() !== 7) begin miscompares++; $display("FAIL bp_tx_count got %0d want 7", tx_log.size()); end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL bp_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_len0_dummy();
      logic [7:0] etx[5];
      etx = '{8'h0B, 8'h12, 8'h34, 8'h56, 8'hFF};
      clear_logs();
      f_start = 1'b1; f_addr = 32'h0012_3456; f_len = 16'd0;
      @(posedge clk); #1 f_start = 1'b0;
      for (int i = 0; i < 2000 && f_busy; i++) @(negedge clk);
      @(posedge clk); #1;
      vectors++; if (f_busy !== 1'b0) begin miscompares++; $display("FAIL len0_timeout busy got %b want 0", f_busy); end
      vectors++; if (ftx_log.size() !== 5) begin miscompares++; $display("FAIL len0_tx_count got %0d want 5", ftx_log.size()); end
      for (int i = 0; i < 5 && i < ftx_log.size(); i++) begin
         vectors++; if (ftx_log[i] !== etx[i]) begin miscompares++; $display("FAIL len0_tx[%0d] got %h want %h", i, ftx_log[i], etx[i]); end
      end
      vectors++; if (fvalid_cnt !== 0) begin miscompares++; $display("FAIL len0_valid_cycles got %0d want 0", fvalid_cnt); end
      vectors++; if (fdone_cnt !== 1) begin miscompares++; $display("FAIL len0_done got %0d want 1", fdone_cnt); end
   endtask

   task automatic test_abort_in_flight();
      logic [7:0] etx[6];
      etx = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF};
      clear_logs();
      out_ready = 1'b1;
      go(32'h0012_3456, 16'd10);
      for (int i = 0; i < 400 && tx_log.size() < 6; i++) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      wait_idle();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_timeout busy got %b want 0", busy); end
      vectors++; if (tx_log.size() !== 6) begin miscompares++; $display("FAIL abort_tx_count got %0d want 6", tx_log.size()); end
      for (int i = 0; i < 6 && i < tx_log.size(); i++) begin
         vectors++; if (tx_log[i] !== etx[i]) begin miscompares++; $display("FAIL abort_tx[%0d] got %h want %h", i, tx_log[i], etx[i]); end
      end
      vectors++; if (out_log.size() !== 1) begin miscompares++; $display("FAIL abort_out_count got %0d want 1", out_log.size()); end
      if (out_log.size() > 0) begin
         vectors++; if (out_log[0] !== 8'hA0) begin miscompares++; $display("FAIL abort_out0 got %h want a0", out_log[0]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL abort_done got %0d want 1", done_cnt); end
      vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL abort_cs_end got %b want 1", spi_cs); end
   endtask

   task automatic test_abort_present();
      clear_logs();
      out_ready = 1'b0;
      go(32'h0012_3456, 16'd3);
      for (int i = 0; i < 400 && out_valid !== 1'b1; i++) @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL abpres_valid_timeout got %b want 1", out_valid); end
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abpres_valid_drop got %b want 0", out_valid); end
      wait_idle();
      vectors++; if (out_log.size() !== 0) begin miscompares++; $display("FAIL abpres_out_count got %0d want 0", out_log.size()); end
      vectors++; if (tx_log.size() !== 5) begin miscompares++; $display("FAIL abpres_tx_count got %0d want 5", tx_log.size()); end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL abpres_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_abort_idle();
      clear_logs();
      out_ready = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(posedge clk); #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abidle_busy got %b want 0", busy); end
      vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL abidle_done got %0d want 0", done_cnt); end
      abort = 1'b1;
      go(32'h0012_3456, 16'd1);
      abort = 1'b0;
      wait_idle();
      vectors++; if (tx_log.size() !== 5) begin miscompares++; $display("FAIL startabort_tx_count got %0d want 5", tx_log.size()); end
      vectors++; if (out_log.size() !== 1) begin miscompares++; $display("FAIL startabort_out_count got %0d want 1", out_log.size()); end
      if (out_log.size() > 0) begin
         vectors++; if (out_log[0] !== 8'hA0) begin miscompares++; $display("FAIL startabort_out0 got %h want a0", out_log[0]); end
      end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL startabort_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_start_while_busy();
      logic [7:0] etx[6];
      etx = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF};
      clear_logs();
      out_ready = 1'b1;
      go(32'h0012_3456, 16'd2);
      repeat (5) @(posedge clk);
      #1;
      go(32'h00AB_CDEF, 16'd7);
      wait_idle();
      vectors++; if (tx_log.size() !== 6) begin miscompares++; $display("FAIL busystart_tx_count got %0d want 6", tx_log.size()); end
      for (int i = 0; i < 6 && i < tx_log.size(); i++) begin
         vectors++; if (tx_log[i] !== etx[i]) begin miscompares++; $display("FAIL busystart_tx[%0d] got %h want %h", i, tx_log[i], etx[i]); end
      end
      vectors++; if (out_log.size() !== 2) begin miscompares++; $display("FAIL busystart_out_count got %0d want 2", out_log.size()); end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL busystart_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] etx[5];
      etx = '{8'h03, 8'h00, 8'h01, 8'h02, 8'hFF};
      clear_logs();
      out_ready = 1'b1;
      go(32'h0012_3456, 16'd5);
      for (int i = 0; i < 400 && spi_idle !== 1'b0; i++) begin @(posedge clk); #1; end
      vectors++; if (spi_idle !== 1'b0) begin miscompares++; $display("FAIL rstmid_wait_timeout idle got %b want 0", spi_idle); end
      done_cnt = 0;
      reset = 1'b1;
      #1;
      vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL rstmid_cs got %b want 1", spi_cs); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy); end
      vectors++; if (spi_byte_tx_strobe !== 1'b0) begin miscompares++; $display("FAIL rstmid_strobe got %b want 0", spi_byte_tx_strobe); end
      @(posedge clk); #1 reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt); end
      clear_logs();
      go(32'h0000_0102, 16'd1);
      wait_idle();
      vectors++; if (tx_log.size() !== 5) begin miscompares++; $display("FAIL rstmid_rerun_tx_count got %0d want 5", tx_log.size()); end
      for (int i = 0; i < 5 && i < tx_log.size(); i++) begin
         vectors++; if (tx_log[i] !== etx[i]) begin miscompares++; $display("FAIL rstmid_rerun_tx[%0d] got %h want %h", i, tx_log[i], etx[i]); end
      end
      vectors++; if (out_log.size() !== 1) begin miscompares++; $display("FAIL rstmid_rerun_out_count got %0d want 1", out_log.size()); end
      vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL rstmid_rerun_done got %0d want 1", done_cnt); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_read();
      test_backpressure();
      test_len0_dummy();
      test_abort_in_flight();
      test_abort_present();
      test_abort_idle();
      test_start_while_busy();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
